// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset cpu: shared ALU, FETCH/DECODE/EXEC/MEM/WB FSM.
// Define OVFL_TRAP_EN to halt on signed overflow of add/sub/addi.
module cpu_multicycle #(
    parameter int unsigned IMEM_AW  = 8,
    parameter int unsigned DMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [31:0]        prog_wdata,
    input  logic [4:0]         dbg_raddr,
    output logic [31:0]        dbg_rdata,
    output logic [31:0]        pc,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal,
    output logic [31:0]        retired
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;

    state_t      r_state, w_nxt;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic        r_illegal;
    logic [31:0] r_retired;
    logic [31:0] r_rf   [32];
    logic [31:0] r_imem [2**IMEM_AW];
    logic [31:0] r_dmem [2**DMEM_AW];

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_wr_idx;
    logic [31:0] w_imm, w_opb, w_alu, w_wr_data, w_br_target;
    logic        w_is_r, w_r_ok, w_is_addi, w_is_lw, w_is_sw;
    logic        w_is_beq, w_is_bne, w_is_bgtz, w_is_br, w_is_halt;
    logic        w_legal, w_br_taken, w_retire, w_set_ill, w_trap;
    logic [IMEM_AW-1:0] w_iaddr;
    logic [DMEM_AW-1:0] w_daddr;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_fn      = r_ir[5:0];
    assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_iaddr   = r_pc[IMEM_AW+1:2];
    assign w_daddr   = r_aluout[DMEM_AW+1:2];

    assign w_is_r    = (w_op == OP_R);
    assign w_r_ok    = w_is_r && (w_fn == F_ADD || w_fn == F_SUB
                     || w_fn == F_AND || w_fn == F_OR
                     || w_fn == F_SLT || w_fn == F_SLL);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_bne  = (w_op == OP_BNE);
    assign w_is_bgtz = (w_op == OP_BGTZ);
    assign w_is_halt = (w_op == OP_HALT);
    assign w_is_br   = w_is_beq | w_is_bne | w_is_bgtz;
    assign w_legal   = w_r_ok | w_is_addi | w_is_lw | w_is_sw | w_is_br;

    assign w_br_taken = (w_is_beq && r_a == r_b)
                      || (w_is_bne && r_a != r_b)
                      || (w_is_bgtz && $signed(r_a) > 0);
    assign w_br_target = r_pc + {w_imm[29:0], 2'b00};

    // Address and addi paths share the adder with R-type add
    assign w_opb = w_is_r ? r_b : w_imm;
    always_comb begin
        w_alu = r_a + w_opb;
        if (w_is_r) begin
            case (w_fn)
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
                F_SLL:   w_alu = r_b << r_ir[10:6];
                default: w_alu = r_a + r_b;
            endcase
        end
    end

`ifdef OVFL_TRAP_EN
    logic w_add_ovf, w_sub_ovf;
    assign w_add_ovf = (r_a[31] == w_opb[31]) && (w_alu[31] != r_a[31]);
    assign w_sub_ovf = (r_a[31] != r_b[31]) && (w_alu[31] != r_a[31]);
    assign w_trap = ((w_is_r && w_fn == F_ADD) || w_is_addi) ? w_add_ovf
                  : (w_is_r && w_fn == F_SUB) ? w_sub_ovf : 1'b0;
`else
    assign w_trap = 1'b0;
`endif

    assign w_wr_idx  = w_is_r ? w_rd : w_rt;
    assign w_wr_data = w_is_lw ? r_mdr : r_aluout;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_retire  = 1'b0;
        w_set_ill = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_nxt = S_FETCH;
            S_FETCH:  w_nxt = S_DECODE;
            S_DECODE: begin
                if (w_is_halt) begin
                    w_nxt    = S_HALT;
                    w_retire = 1'b1;
                end else if (!w_legal) begin
                    w_nxt     = S_HALT;
                    w_set_ill = 1'b1;
                end else begin
                    w_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_trap) begin
                    w_nxt     = S_HALT;
                    w_set_ill = 1'b1;
                end else if (w_is_br) begin
                    w_nxt    = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_is_lw || w_is_sw) begin
                    w_nxt = S_MEM;
                end else begin
                    w_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (w_is_sw) begin
                    w_nxt    = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_nxt = S_WB;
                end
            end
            S_WB: begin
                w_nxt    = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_nxt = S_HALT;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            if (w_retire)  r_retired <= r_retired + 32'd1;
            if (w_set_ill) r_illegal <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    r_ir <= r_imem[w_iaddr];
                    r_pc <= r_pc + 32'd4;
                end
                S_DECODE: begin
                    r_a <= (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
                    r_b <= (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    if (w_is_br && w_br_taken) r_pc <= w_br_target;
                end
                S_MEM: if (w_is_lw) r_mdr <= r_dmem[w_daddr];
                S_WB: if (w_wr_idx != 5'd0) r_rf[w_wr_idx] <= w_wr_data;
                default: ;
            endcase
        end
    end

    // Memories are never cleared; a reset edge still blocks the store
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_MEM && w_is_sw) r_dmem[w_daddr] <= r_b;
    end

    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE || r_state == S_HALT))
            r_imem[prog_addr] <= prog_wdata;
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : r_rf[dbg_raddr];
    assign pc        = r_pc;
    assign state     = r_state;
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;
    assign retired   = r_retired;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: table of small programs plus branch,
// reset-during-store and halt-freeze sequences.
module tb_cpu_multicycle;
    localparam int OP_ADDI = 6'b001000;
    localparam int OP_LW   = 6'b100011;
    localparam int OP_SW   = 6'b101011;
    localparam int OP_BEQ  = 6'b000100;
    localparam int OP_BNE  = 6'b000101;
    localparam int OP_BGTZ = 6'b000111;
    localparam int F_ADD   = 6'b100000;
    localparam int F_SUB   = 6'b100010;
    localparam int F_AND   = 6'b100100;
    localparam int F_OR    = 6'b100101;
    localparam int F_SLT   = 6'b101010;
    localparam int F_SLL   = 6'b000000;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata, pc, retired;
    logic [2:0]  st;
    logic        halted, illegal;

    int checks = 0;
    int errors = 0;

    cpu_multicycle dut (
        .clk(clk), .rst(rst), .run(run),
        .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .pc(pc), .state(st), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0][31:0] prog;
        logic [3:0]       n;
        logic [4:0]       ridx;
        logic [31:0]      rval;
        logic [31:0]      ret;
        logic             ill;
        logic [31:0]      cyc;
        logic [31:0]      pc;
    } vec_t;

    vec_t v [NV];

    function automatic logic [31:0] enc_i(input int op, input int rs,
                                          input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt,
                                          input int rd, input int sh,
                                          input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic vec_t mkv(
        input logic [31:0] p0, p1, p2, p3, p4, p5,
        input int n, input int ridx, input logic [31:0] rval,
        input int ret, input int ill, input int cyc, input int epc);
        vec_t f;
        f.prog[0] = p0; f.prog[1] = p1; f.prog[2] = p2;
        f.prog[3] = p3; f.prog[4] = p4; f.prog[5] = p5;
        f.n = n[3:0];
        f.ridx = ridx[4:0];
        f.rval = rval;
        f.ret = ret;
        f.ill = ill[0];
        f.cyc = cyc;
        f.pc = epc;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a[7:0];
        prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic rd(input int r, output logic [31:0] val);
        dbg_raddr = r[4:0];
        #1;
        val = dbg_rdata;
    endtask

    task automatic run_to_halt(output int cyc);
        run = 1'b1;
        tick();
        run = 1'b0;
        cyc = 0;
        while (!halted && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] val;
        int c;
        logic [31:0] bprog [11];
        logic [31:0] exp_pc [8];
        int exp_cy [8];
        logic [31:0] got_pc [$];
        int got_cy [$];

        v[0] = mkv(enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_ADDI, 0, 2, 7),
                   enc_r(1, 2, 3, 0, F_ADD), HLT, 0, 0,
                   4, 3, 32'd12, 4, 0, 14, 32'h10);
        v[1] = mkv(enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_ADDI, 0, 2, 7),
                   enc_r(1, 2, 3, 0, F_SUB), HLT, 0, 0,
                   4, 3, 32'hFFFF_FFFE, 4, 0, 14, 32'h10);
        v[2] = mkv(enc_i(OP_ADDI, 0, 1, 12), enc_i(OP_ADDI, 0, 2, 10),
                   enc_r(1, 2, 3, 0, F_OR), HLT, 0, 0,
                   4, 3, 32'd14, 4, 0, 14, 32'h10);
        v[3] = mkv(enc_i(OP_ADDI, 0, 1, 12), enc_i(OP_ADDI, 0, 2, 10),
                   enc_r(1, 2, 3, 0, F_AND), HLT, 0, 0,
                   4, 3, 32'd8, 4, 0, 14, 32'h10);
        v[4] = mkv(enc_i(OP_ADDI, 0, 1, -1), enc_i(OP_ADDI, 0, 2, 1),
                   enc_r(1, 2, 3, 0, F_SLT), HLT, 0, 0,
                   4, 3, 32'd1, 4, 0, 14, 32'h10);
        v[5] = mkv(enc_i(OP_ADDI, 0, 1, 3), enc_r(0, 1, 3, 4, F_SLL),
                   HLT, 0, 0, 0,
                   3, 3, 32'd48, 3, 0, 10, 32'h0C);
        v[6] = mkv(enc_i(OP_ADDI, 0, 0, 9), HLT, 0, 0, 0, 0,
                   2, 0, 32'd0, 2, 0, 6, 32'h08);
        v[7] = mkv(enc_i(OP_ADDI, 0, 1, 1), enc_i(6'b010101, 0, 0, 0),
                   HLT, 0, 0, 0,
                   3, 1, 32'd1, 1, 1, 6, 32'h08);
        v[8] = mkv(enc_i(OP_ADDI, 0, 1, 1), enc_r(1, 1, 2, 0, 6'b100001),
                   HLT, 0, 0, 0,
                   3, 2, 32'd0, 1, 1, 6, 32'h08);
        v[9] = mkv(enc_i(OP_ADDI, 0, 3, 12), enc_i(OP_SW, 0, 3, 4),
                   enc_i(OP_LW, 0, 4, 4), HLT, 0, 0,
                   4, 4, 32'd12, 4, 0, 15, 32'h10);
`ifdef OVFL_TRAP_EN
        v[10] = mkv(enc_i(OP_ADDI, 0, 1, 1), enc_r(0, 1, 2, 30, F_SLL),
                    enc_i(OP_ADDI, 2, 3, -1), enc_r(3, 2, 4, 0, F_OR),
                    enc_r(4, 1, 6, 0, F_ADD), HLT,
                    6, 6, 32'd0, 4, 1, 19, 32'h14);
`else
        v[10] = mkv(enc_i(OP_ADDI, 0, 1, 1), enc_r(0, 1, 2, 30, F_SLL),
                    enc_i(OP_ADDI, 2, 3, -1), enc_r(3, 2, 4, 0, F_OR),
                    enc_r(4, 1, 6, 0, F_ADD), HLT,
                    6, 6, 32'h8000_0000, 6, 0, 22, 32'h18);
`endif
        v[11] = mkv(enc_i(OP_ADDI, 0, 3, 42), enc_i(OP_SW, 0, 3, 4),
                    enc_i(OP_LW, 0, 4, 16'h0406), HLT, 0, 0,
                    4, 4, 32'd42, 4, 0, 15, 32'h10);

        // Reset state and run-gated idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", {29'd0, st}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        tick();
        tick();
        chk("idle_hold", {29'd0, st}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            for (int k = 0; k < int'(v[i].n); k++)
                load_word(k, v[i].prog[k]);
            run_to_halt(c);
            chk($sformatf("v%0d_cycles", i), c, v[i].cyc);
            chk($sformatf("v%0d_pc", i), pc, v[i].pc);
            chk($sformatf("v%0d_retired", i), retired, v[i].ret);
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal},
                {31'd0, v[i].ill});
            chk($sformatf("v%0d_state", i), {29'd0, st}, 32'd6);
            rd(v[i].ridx, val);
            chk($sformatf("v%0d_reg%0d", i, v[i].ridx), val, v[i].rval);
        end

        // Branch sequence: record pc and cycle at every FETCH entry
        bprog = '{enc_i(OP_ADDI, 0, 1, 1), enc_i(OP_ADDI, 0, 2, -1),
                  enc_i(OP_BNE, 1, 1, 5), enc_i(OP_BGTZ, 2, 0, 5),
                  enc_i(OP_BEQ, 1, 1, 2), HLT, HLT,
                  enc_i(OP_BGTZ, 1, 0, 1), HLT,
                  enc_i(OP_ADDI, 0, 5, 7), HLT};
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C,
                   32'h10, 32'h1C, 32'h24, 32'h28};
        exp_cy = '{0, 4, 8, 11, 14, 17, 20, 24};
        do_reset();
        for (int k = 0; k < 11; k++) load_word(k, bprog[k]);
        run = 1'b1;
        tick();
        run = 1'b0;
        c = 0;
        while (c < 400) begin
            if (st == 3'd1) begin
                got_pc.push_back(pc);
                got_cy.push_back(c);
            end
            if (halted) break;
            tick();
            c++;
        end
        chk("br_halt_cycle", c, 32'd26);
        chk("br_fetch_count", got_pc.size(), 32'd8);
        for (int k = 0; k < 8 && k < got_pc.size(); k++) begin
            chk($sformatf("br_fetch%0d_pc", k), got_pc[k], exp_pc[k]);
            chk($sformatf("br_fetch%0d_cyc", k), got_cy[k], exp_cy[k]);
        end
        chk("br_retired", retired, 32'd8);
        rd(5, val);
        chk("br_reg5", val, 32'd7);

        // HALT is frozen and ignores run
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        chk("halt_state", {29'd0, st}, 32'd6);
        chk("halt_pc", pc, 32'h2C);
        chk("halt_retired", retired, 32'd8);

        // Seed dmem word 2, then reset in the MEM cycle of a store to it
        do_reset();
        load_word(0, enc_i(OP_ADDI, 0, 3, 16'h55));
        load_word(1, enc_i(OP_SW, 0, 3, 8));
        load_word(2, enc_i(OP_LW, 0, 4, 8));
        load_word(3, HLT);
        run_to_halt(c);
        rd(4, val);
        chk("seed_reg4", val, 32'h55);

        do_reset();
        load_word(0, enc_i(OP_ADDI, 0, 3, 16'h66));
        load_word(1, enc_i(OP_SW, 0, 3, 8));
        load_word(2, HLT);
        run = 1'b1;
        tick();
        run = 1'b0;
        c = 0;
        while (st != 3'd4 && c < 50) begin
            tick();
            c++;
        end
        chk("sw_mem_state", {29'd0, st}, 32'd4);
        chk("sw_mem_cycle", c, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_state", {29'd0, st}, 32'd0);
        chk("mrst_pc", pc, 32'd0);
        chk("mrst_retired", retired, 32'd0);
        for (int r = 1; r < 32; r++) begin
            rd(r, val);
            chk($sformatf("mrst_reg%0d", r), val, 32'd0);
        end
        load_word(0, enc_i(OP_LW, 0, 4, 8));
        load_word(1, HLT);
        run_to_halt(c);
        rd(4, val);
        chk("mrst_dmem_kept", val, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS-subset cpu top. One shared ALU and a control FSM step each instruction through FETCH/DECODE/EXEC/MEM/WB, so instructions take variable cycle counts. Instruction memory, data memory and register file are internal. A program-load port and a debug register read port replace hard-coded memory init. Adds halt/illegal-opcode detection and a retired-instruction counter.

Parameters:
IMEM_AW, 8, instruction memory address width in words (depth 2**IMEM_AW).
DMEM_AW, 8, data memory address width in words (depth 2**DMEM_AW).
RESET_PC, 32'h0000_0000, byte address loaded into pc on reset; word aligned.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-high.
run  in  1  in IDLE, start execution at pc.
prog_we  in  1  instruction-memory write strobe.
prog_addr  in  IMEM_AW  word address for prog_we.
prog_wdata  in  32  instruction word to write.
dbg_raddr  in  5  register-file debug read index.
dbg_rdata  out  32  combinational read of reg[dbg_raddr]; reg 0 reads 0.
pc  out  32  current program counter (byte address).
state  out  3  FSM state: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6.
halted  out  1  high in HALT.
illegal  out  1  sticky; set on entering HALT via an unknown opcode.
retired  out  32  count of completed instructions; wraps modulo 2**32.

Behaviour:
- Reset (rst=1 at edge, any state, including mid-instruction): state=IDLE, pc=RESET_PC, registers 1-31=0, illegal=0, retired=0, IR=0; the in-flight instruction is abandoned with no register/memory write that cycle. Instruction and data memories are not cleared.
- IDLE: run=1 -> FETCH; otherwise stay. prog_we writes imem[prog_addr] only in IDLE or HALT; ignored in other states.
- FETCH: IR <= imem[pc[IMEM_AW+1:2]]; pc <= pc+4; -> DECODE.
- DECODE: A <= reg[rs], B <= reg[rt]. Opcode 6'b111111 -> HALT (illegal stays 0, counted as retired). Opcodes not in the supported set -> HALT, illegal=1, not retired. Else -> EXEC.
- Supported: R-type (op 0) with func add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000 (rt << shamt). addi 001000 (sign-extended imm), lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111 (A signed > 0). An R-type with an unsupported func is illegal.
- EXEC: ALUOut computed. Branches: if taken, pc <= pc + (sext(imm)<<2), using pc already incremented; retire; -> FETCH. lw/sw -> MEM. R-type/addi -> WB.
- MEM: address = ALUOut[DMEM_AW+1:2] (low 2 bits ignored; upper bits truncated, wraps). sw: dmem write B; retire; -> FETCH. lw: MDR <= dmem; -> WB.
- WB: R-type writes rd, addi writes rt, lw writes rt with MDR; writes to reg 0 are discarded; retire; -> FETCH.
- Cycle counts from FETCH entry: branch 3, R-type/addi/sw 4, lw 5.
- Arithmetic is 32-bit two's complement; add/sub/addi wrap unless OVFL_TRAP_EN is defined.
- retired increments on the same edge as the final state transition of the instruction.
- HALT: all state frozen; only rst exits.
- run is ignored outside IDLE.

Optional Feature:
OVFL_TRAP_EN: when defined, signed overflow on add/sub/addi in EXEC suppresses WB, leaves pc = address of faulting instr + 4, sets illegal=1, -> HALT (not retired). When undefined, results wrap and are written normally.

Test Plan:
Load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt; run -> HALT after 4+4+4+2 cycles; dbg reg3=12; retired=4; illegal=0.
sw $3,4($0); lw $4,4($0) after reg3=12 -> reg4=12; lw takes 5 cycles, sw 4.
beq $1,$1,+2 at pc 0x10 -> next FETCH pc=0x1C; bne equal regs -> pc=0x14; bgtz on reg=-1 -> not taken.
addi $0,$0,9 -> reg0 still reads 0; opcode 6'b010101 -> HALT, illegal=1, retired unchanged.
Assert rst during MEM of a sw -> target dmem word unchanged, state=0, pc=RESET_PC, reg1..31=0.
With OVFL_TRAP_EN: 0x7FFFFFFF + 1 via add -> rd unchanged, HALT, illegal=1; without the macro, rd=0x80000000.
